// File: rtl/cu_sequencer.sv
// cu_sequencer
//   Control unit for the InMux / RegFile / ALU / OutMux datapath. One start
//   request runs one of four operations on InA/InB: ADD, SUB (A-B),
//   ABS (|A-B|) or SATSUB (max(A-B,0)). Subtraction is built as
//   A + (~B + 1) using the ALU XOR and ADD operations. The ABS correction
//   path negates the difference the same way.
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   start          operation request, sampled in IDLE only
//   mode[1:0]      0=ADD 1=SUB 2=ABS 3=SATSUB, latched with start
//   co, z          ALU carry-out / zero flags, consulted in CHECK
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   we             register-file write enable
//   ins_sel[1:0]   ALU op: 0=pass 1=XOR 2=ADD
//   in_mux_add     0=InA 1=InB 2=cu_const 3=ALUout 4=RegOut
//   out_mux_add    register-file read address
//   reg_add        write address: 0=Out 1=ALUinA 2=ALUinB 3=scratch
//   cu_const       constant injected into the datapath
//
// All control outputs are registered. They are decoded from the next state,
// so each output is valid in the same cycle as the state it belongs to.

module cu_sequencer #(
  parameter int W    = 8,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic            co,
  input  logic            z,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [1:0]      ins_sel,
  output logic [2:0]      in_mux_add,
  output logic [RA_W-1:0] out_mux_add,
  output logic [RA_W-1:0] reg_add,
  output logic [W-1:0]    cu_const
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_NB_X   = 4'd3,
    S_NB_XW  = 4'd4,
    S_NB_I   = 4'd5,
    S_NB_IW  = 4'd6,
    S_ADD_R  = 4'd7,
    S_CHECK  = 4'd8,
    S_R_W    = 4'd9,
    S_R_X    = 4'd10,
    S_R_XW   = 4'd11,
    S_R_I    = 4'd12,
    S_OUT    = 4'd13,
    S_ZERO   = 4'd14,
    S_DONE   = 4'd15
  } state_t;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            we;
    logic [1:0]      ins_sel;
    logic [2:0]      in_mux;
    logic [RA_W-1:0] out_mux;
    logic [RA_W-1:0] reg_add;
    logic [W-1:0]    cu_const;
  } ctrl_t;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_ABS = 2'd2;

  state_t     state_q, state_n;
  logic [1:0] mode_q;
  ctrl_t      ctrl_q, ctrl_n;

  // Control word for a given state; anything not set stays 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_LOAD_A: begin
        c.we = 1'b1; c.in_mux = 3'd0; c.reg_add = RA_W'(3);
      end
      S_LOAD_B: begin
        c.we = 1'b1; c.in_mux = 3'd1; c.reg_add = RA_W'(1);
      end
      S_NB_X, S_R_X: begin
        c.we = 1'b1; c.in_mux = 3'd2; c.reg_add = RA_W'(2);
        c.cu_const = '1; c.ins_sel = 2'd1;
      end
      S_NB_XW, S_NB_IW, S_R_W, S_R_XW: begin
        c.we = 1'b1; c.in_mux = 3'd3; c.reg_add = RA_W'(1);
      end
      S_NB_I, S_R_I: begin
        c.we = 1'b1; c.in_mux = 3'd2; c.reg_add = RA_W'(2);
        c.cu_const = W'(1); c.ins_sel = 2'd2;
      end
      S_ADD_R: begin
        c.we = 1'b1; c.in_mux = 3'd4; c.out_mux = RA_W'(3);
        c.reg_add = RA_W'(2); c.ins_sel = 2'd2;
      end
      S_CHECK: begin
        c.ins_sel = 2'd2; c.out_mux = RA_W'(3);
      end
      S_OUT: begin
        c.we = 1'b1; c.in_mux = 3'd3; c.reg_add = RA_W'(0);
      end
      S_ZERO: begin
        c.we = 1'b1; c.in_mux = 3'd2; c.cu_const = '0; c.reg_add = RA_W'(0);
      end
      S_DONE: begin
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:   if (start) state_n = S_LOAD_A;
      S_LOAD_A: state_n = S_LOAD_B;
      S_LOAD_B: state_n = (mode_q == MODE_ADD) ? S_ADD_R : S_NB_X;
      S_NB_X:   state_n = S_NB_XW;
      S_NB_XW:  state_n = S_NB_I;
      S_NB_I:   state_n = S_NB_IW;
      S_NB_IW:  state_n = S_ADD_R;
      S_ADD_R:  state_n = S_CHECK;
      // co=1 means A>=B, z=1 means A==B; only ABS/SATSUB act on them.
      S_CHECK: begin
        if (mode_q == MODE_ADD || mode_q == MODE_SUB || co || z)
          state_n = S_OUT;
        else if (mode_q == MODE_ABS)
          state_n = S_R_W;
        else
          state_n = S_ZERO;
      end
      S_R_W:    state_n = S_R_X;
      S_R_X:    state_n = S_R_XW;
      S_R_XW:   state_n = S_R_I;
      S_R_I:    state_n = S_OUT;
      S_OUT:    state_n = S_DONE;
      S_ZERO:   state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    ctrl_n = decode(state_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_n;
      ctrl_q  <= ctrl_n;
      if (state_q == S_IDLE && start) mode_q <= mode;
    end
  end

  assign busy        = ctrl_q.busy;
  assign done        = ctrl_q.done;
  assign we          = ctrl_q.we;
  assign ins_sel     = ctrl_q.ins_sel;
  assign in_mux_add  = ctrl_q.in_mux;
  assign out_mux_add = ctrl_q.out_mux;
  assign reg_add     = ctrl_q.reg_add;
  assign cu_const    = ctrl_q.cu_const;

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: a small datapath model (InMux, RegFile, ALU) closes
// the loop on co/z; a step-list reference model predicts the control trace
// and the Out register for every operation.
module tb_cu_sequencer;
  localparam int W    = 8;
  localparam int RA_W = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            co, z;
  logic            busy, done, we;
  logic [1:0]      ins_sel;
  logic [2:0]      in_mux_add;
  logic [RA_W-1:0] out_mux_add, reg_add;
  logic [W-1:0]    cu_const;

  int errors = 0;
  int checks = 0;

  cu_sequencer #(.W(W), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .co(co), .z(z),
    .busy(busy), .done(done), .we(we), .ins_sel(ins_sel),
    .in_mux_add(in_mux_add), .out_mux_add(out_mux_add), .reg_add(reg_add),
    .cu_const(cu_const)
  );

  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  // The ALU applies the op selected in the previous cycle, so an op chosen
  // together with an operand write acts on the freshly written operand.
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] rf [16];
  logic [1:0]   alu_op_q = 2'd0;
  logic [W:0]   alu_sum;
  logic [W-1:0] alu_out, mux_val;

  always_comb begin
    alu_sum = {1'b0, rf[1]} + {1'b0, rf[2]};
    case (alu_op_q)
      2'd1:    alu_out = rf[1] ^ rf[2];
      2'd2:    alu_out = alu_sum[W-1:0];
      default: alu_out = rf[1];
    endcase
    co = (alu_op_q == 2'd2) && alu_sum[W];
    z  = (alu_out == '0);
    case (in_mux_add)
      3'd0:    mux_val = in_a;
      3'd1:    mux_val = in_b;
      3'd2:    mux_val = cu_const;
      3'd3:    mux_val = alu_out;
      3'd4:    mux_val = rf[out_mux_add];
      default: mux_val = '0;
    endcase
  end

  always @(posedge clk) begin
    alu_op_q <= ins_sel;
    if (we) rf[reg_add] <= mux_val;
  end

  // ---------------- reference model ----------------
  // Vector layout: {busy, done, we, ins_sel, in_mux, out_mux, reg_add, cu_const}
  localparam logic [23:0] V_LA   = {1'b1,1'b0,1'b1,2'd0,3'd0,4'd0,4'd3,8'h00};
  localparam logic [23:0] V_LB   = {1'b1,1'b0,1'b1,2'd0,3'd1,4'd0,4'd1,8'h00};
  localparam logic [23:0] V_X    = {1'b1,1'b0,1'b1,2'd1,3'd2,4'd0,4'd2,8'hFF};
  localparam logic [23:0] V_W1   = {1'b1,1'b0,1'b1,2'd0,3'd3,4'd0,4'd1,8'h00};
  localparam logic [23:0] V_I    = {1'b1,1'b0,1'b1,2'd2,3'd2,4'd0,4'd2,8'h01};
  localparam logic [23:0] V_ADDR = {1'b1,1'b0,1'b1,2'd2,3'd4,4'd3,4'd2,8'h00};
  localparam logic [23:0] V_CHK  = {1'b1,1'b0,1'b0,2'd2,3'd0,4'd3,4'd0,8'h00};
  localparam logic [23:0] V_OUT  = {1'b1,1'b0,1'b1,2'd0,3'd3,4'd0,4'd0,8'h00};
  localparam logic [23:0] V_ZERO = {1'b1,1'b0,1'b1,2'd0,3'd2,4'd0,4'd0,8'h00};
  localparam logic [23:0] V_DONE = {1'b1,1'b1,1'b0,2'd0,3'd0,4'd0,4'd0,8'h00};

  logic [23:0]  exp_q[$];
  logic [W-1:0] cur_exp_out = '0;

  task automatic build(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back(V_LA);
    exp_q.push_back(V_LB);
    if (m == 2'd0) begin
      exp_q.push_back(V_ADDR); exp_q.push_back(V_CHK);
      exp_q.push_back(V_OUT);  exp_q.push_back(V_DONE);
      cur_exp_out = a + b;
    end else begin
      exp_q.push_back(V_X);    exp_q.push_back(V_W1);
      exp_q.push_back(V_I);    exp_q.push_back(V_W1);
      exp_q.push_back(V_ADDR); exp_q.push_back(V_CHK);
      if (m == 2'd1 || a >= b) begin
        exp_q.push_back(V_OUT); exp_q.push_back(V_DONE);
        cur_exp_out = a - b;
      end else if (m == 2'd2) begin
        exp_q.push_back(V_W1); exp_q.push_back(V_X);
        exp_q.push_back(V_W1); exp_q.push_back(V_I);
        exp_q.push_back(V_OUT); exp_q.push_back(V_DONE);
        cur_exp_out = b - a;
      end else begin
        exp_q.push_back(V_ZERO); exp_q.push_back(V_DONE);
        cur_exp_out = '0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (start) build(mode, in_a, in_b);
  end

  // Per-cycle comparison of the whole control word, plus Out at each done.
  always @(negedge clk) begin
    logic [23:0] act, expv;
    act  = {busy, done, we, ins_sel, in_mux_add, out_mux_add, reg_add, cu_const};
    expv = (exp_q.size() != 0) ? exp_q[0] : 24'h0;
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL trace t=%0t actual=%06h required=%06h", $time, act, expv);
    end
    if (expv[22]) begin
      checks++;
      if (rf[0] !== cur_exp_out) begin
        errors++;
        $display("FAIL out_reg t=%0t actual=%02h required=%02h", $time, rf[0], cur_exp_out);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts one operation from an IDLE cycle (called at a negedge) and waits
  // for done. exp_lat < 0 skips the literal latency/result checks.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_out);
    int cnt;
    bit got;
    mode = m; in_a = a; in_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    got = 1'b0;
    if (exp_lat >= 0) check("busy_cycle1", {31'd0, busy}, 32'd1);
    while (!got && cnt <= 40) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    else if (exp_lat >= 0) begin
      check("latency", cnt, exp_lat);
      check("out_value", {24'd0, rf[0]}, {24'd0, exp_out});
    end
    @(negedge clk);
  endtask

  initial begin
    int dones;
    logic [1:0]   rm;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, we, ins_sel, in_mux_add, out_mux_add, reg_add, cu_const}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(2'd0, 8'h05, 8'h03, 6,  8'h08);
    run_op(2'd1, 8'h05, 8'h03, 10, 8'h02);
    run_op(2'd1, 8'h03, 8'h05, 10, 8'hFE);
    run_op(2'd2, 8'h03, 8'h05, 14, 8'h02);
    run_op(2'd2, 8'h7F, 8'h7F, 10, 8'h00);
    run_op(2'd3, 8'h03, 8'h05, 10, 8'h00);
    run_op(2'd3, 8'h10, 8'h01, 10, 8'h0F);

    // start held for 20 cycles, mode scrambled while busy
    in_a = 8'h21; in_b = 8'h13; mode = 2'd0; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
      mode = (exp_q.size() == 0) ? 2'd0 : 2'($urandom_range(0, 3));
    end
    start = 1'b0; mode = 2'd0;
    check("held_start_dones", dones, 32'd3);
    @(negedge clk);
    check("held_start_idle", {31'd0, busy}, 32'd0);

    // reset in NB_I of a SUB
    mode = 2'd1; in_a = 8'h40; in_b = 8'h11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("in_nb_i", {27'd0, ins_sel, in_mux_add}, {27'd0, 2'd2, 3'd2});
    #1 reset = 1'b1;
    #1 check("reset_mid_op", {busy, done, we, ins_sel, in_mux_add, out_mux_add, reg_add, cu_const}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_stale_done", {31'd0, done}, 32'd0);
    end
    run_op(2'd1, 8'h40, 8'h11, 10, 8'h2F);

    // randomized operations
    repeat (40) begin
      rm = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      // two-step negation of B=0 loses the carry; keep B nonzero when flags matter
      if (rm >= 2'd2 && rb == '0 && ra != '0) rb = W'(1);
      run_op(rm, ra, rb, -1, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Parametrised control unit for the register-file / ALU datapath (InMux, RegFile, ALU, OutMux).
- Runs one of four arithmetic modes on inputs InA/InB per start request: ADD, SUB, ABS-difference, SUB saturating at 0.
- Drives mux, register-address, constant, ALU-select and write-enable controls; reacts to ALU flags co/z.
- Adds a start/busy/done handshake.

Parameters:
W, 8, datapath width; width of cu_const
RA_W, 4, register/out-mux address width

Ports:
clk  in  1  clock
reset  in  1  async reset
start  in  1  operation request, sampled in IDLE only
mode  in  2  0=ADD, 1=SUB (A-B), 2=ABS (|A-B|), 3=SATSUB (max(A-B,0)); latched at start
co  in  1  ALU carry-out
z  in  1  ALU zero flag
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
we  out  1  register-file write enable
ins_sel  out  2  ALU op: 0=pass, 1=XOR, 2=ADD
in_mux_add  out  3  0=InA, 1=InB, 2=cu_const, 3=ALUout, 4=RegOut
out_mux_add  out  RA_W  register-file read address
reg_add  out  RA_W  write address: 0=Out, 1=ALUinA, 2=ALUinB, 3=scratch
cu_const  out  W  constant injected into datapath

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- On reset: state=IDLE, mode register=0, all outputs 0.
- Outputs are registers loaded from decode(next_state); they are valid in the same cycle as the state they belong to.
- Every output not listed for a state is 0.
- busy=1 in every state except IDLE.
- Per-state outputs:
  - IDLE: all 0. If start=1, latch mode and go to LOAD_A; otherwise stay.
  - LOAD_A: we=1, in_mux=0, reg_add=3.
  - LOAD_B: we=1, in_mux=1, reg_add=1. Next state is ADD_R if mode=0, else NB_X.
  - NB_X: we=1, in_mux=2, reg_add=2, cu_const=all ones, ins_sel=1.
  - NB_XW: we=1, in_mux=3, reg_add=1.
  - NB_I: we=1, in_mux=2, reg_add=2, cu_const=1, ins_sel=2.
  - NB_IW: we=1, in_mux=3, reg_add=1.
  - ADD_R: we=1, in_mux=4, out_mux=3, reg_add=2, ins_sel=2.
  - CHECK: we=0, ins_sel=2, out_mux=3. co/z are sampled at the end of this cycle.
    - mode 0/1 -> OUT.
    - mode 2: z|co -> OUT, else -> R_W.
    - mode 3: z|co -> OUT, else -> ZERO.
  - R_W: we=1, in_mux=3, reg_add=1.
  - R_X: we=1, in_mux=2, reg_add=2, cu_const=all ones, ins_sel=1.
  - R_XW: we=1, in_mux=3, reg_add=1.
  - R_I: we=1, in_mux=2, reg_add=2, cu_const=1, ins_sel=2. Next state is OUT.
  - OUT: we=1, in_mux=3, reg_add=0. Next state is DONE.
  - ZERO: we=1, in_mux=2, cu_const=0, reg_add=0. Next state is DONE.
  - DONE: done=1, we=0. Next state is IDLE.
- Latency: cycle 0 is the cycle start is sampled high in IDLE; done is high in cycle N.
  - ADD: N=6.
  - SUB, and ABS/SATSUB with A>=B: N=10.
  - ABS with A<B: N=14.
  - SATSUB with A<B: N=10 (ZERO replaces OUT).
- Flag convention: co=1 from A+~B+1 means A>=B; z=1 means equal.
- Arithmetic is modulo 2^W. ADD overflow is not flagged.
- start while busy (including in DONE) is ignored; it is not queued.
- mode changes after latching have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse.
- Unused 4-bit state encodings recover to IDLE on the next clock.

Test Plan:
- The bench pairs the block with a behavioural datapath model (W=8) and checks the Out register and the control trace.
- ADD, A=0x05, B=0x03, start one cycle -> Out=0x08, done at cycle 6, busy high in cycles 1-6.
- SUB, A=0x05, B=0x03 -> Out=0x02 via OUT, done at cycle 10. SUB, A=0x03, B=0x05 -> Out=0xFE.
- ABS, A=0x03, B=0x05 -> co=0 at CHECK, R_* path taken, Out=0x02, done at cycle 14. ABS, A=B=0x7F -> z=1, Out=0x00, done at cycle 10.
- SATSUB, A=0x03, B=0x05 -> ZERO state, Out=0x00, cu_const=0, done at cycle 10. SATSUB, A=0x10, B=0x01 -> Out=0x0F.
- start held high for 20 cycles in ADD mode -> back-to-back operations with one IDLE cycle between done and the next LOAD_A; mode toggled mid-operation is ignored.
- reset asserted in NB_I -> outputs 0 and state IDLE on the same edge; next start completes normally with no stale done.
